// File: rtl/seq_arb_4in_weighted_lock_pkg.sv
// Shared constants, FSM state type and small helpers for the weighted
// round-robin arbiter.
package seq_arb_4in_weighted_lock_pkg;
   localparam int NUM_REQS  = 4;
   localparam int W_BITS    = 2;   // programmed weight field per requester
   localparam int CRED_BITS = 3;   // holds effective weight 1..4
   localparam int PTR_BITS  = 2;

   typedef enum logic {IDLE, GRANT} state_t;

   // Effective weight is the programmed field plus one.
   function automatic logic [CRED_BITS-1:0] weight_of(input logic [W_BITS-1:0] w);
      weight_of = CRED_BITS'(w) + CRED_BITS'(1);
   endfunction

   // One-hot to index; returns 0 for an all-zero vector.
   function automatic logic [PTR_BITS-1:0] oh2idx(input logic [NUM_REQS-1:0] oh);
      oh2idx = '0;
      for (int i = 0; i < NUM_REQS; i++)
         if (oh[i]) oh2idx = PTR_BITS'(i);
   endfunction
endpackage

// File: rtl/seq_arb_4in_weighted_lock_if.sv
// Requester-side bus of the arbiter: config, requests, completions, grants.
interface seq_arb_4in_weighted_lock_if;
   import seq_arb_4in_weighted_lock_pkg::*;
   logic                     cfg_en;
   logic [2*NUM_REQS-1:0]    cfg_weights;
   logic [NUM_REQS-1:0]      reqs;
   logic [NUM_REQS-1:0]      dones;
   logic [NUM_REQS-1:0]      grants;
   logic                     timeout;

   modport master (output cfg_en, cfg_weights, reqs, dones,
                   input  grants, timeout);
   modport slave  (input  cfg_en, cfg_weights, reqs, dones,
                   output grants, timeout);
endinterface

// File: rtl/seq_arb_4in_weighted_lock_pick.sv
// Round-robin picker: first eligible requester at or after the pointer.
module arb_4in_rr_pick
   import seq_arb_4in_weighted_lock_pkg::*;
(
   input  logic [NUM_REQS-1:0] eligible,
   input  logic [PTR_BITS-1:0] ptr,
   output logic [NUM_REQS-1:0] pick
);
   // Scan farthest-first so the closest eligible index to ptr wins last.
   always_comb begin
      logic [PTR_BITS-1:0] w_idx;
      pick  = '0;
      w_idx = '0;
      for (int k = NUM_REQS-1; k >= 0; k--) begin
         w_idx = ptr + PTR_BITS'(k);
         if (eligible[w_idx]) begin
            pick        = '0;
            pick[w_idx] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/seq_arb_4in_weighted_lock.sv
// Four-requester weighted round-robin arbiter with held grants, hold
// timeout and run-time programmable weights.
module seq_arb_4in_weighted_lock
   import seq_arb_4in_weighted_lock_pkg::*;
#(
   parameter int MAX_HOLD = 15
) (
   input logic                     clk,
   input logic                     reset,
   seq_arb_4in_weighted_lock_if.slave bus
);
   localparam int HOLD_BITS = $clog2(MAX_HOLD+1);

   state_t                             r_state;
   logic [NUM_REQS-1:0]                r_grants;
   logic                               r_timeout;
   logic [2*NUM_REQS-1:0]              r_weights;
   logic [NUM_REQS-1:0][CRED_BITS-1:0] r_credit;
   logic [PTR_BITS-1:0]                r_ptr;
   logic [HOLD_BITS-1:0]               r_hold;

   logic [NUM_REQS-1:0]                w_nz;
   logic                               w_reload;
   logic [NUM_REQS-1:0][CRED_BITS-1:0] w_cred_eff;
   logic [NUM_REQS-1:0][CRED_BITS-1:0] w_cred_nxt;
   logic [NUM_REQS-1:0]                w_elig;
   logic [NUM_REQS-1:0]                w_pick;
   logic [PTR_BITS-1:0]                w_pick_idx;
   logic [PTR_BITS-1:0]                w_hold_idx;
   logic                               w_release;
   logic                               w_expire;
   logic                               w_issue;

   assign bus.grants  = r_grants;
   assign bus.timeout = r_timeout;

   // Eligibility, with an in-cycle credit reload when active requesters
   // have all run dry.
   always_comb begin
      w_nz = '0;
      for (int i = 0; i < NUM_REQS; i++) w_nz[i] = (r_credit[i] != '0);
      w_reload = (|bus.reqs) && !(|(bus.reqs & w_nz));
      w_cred_eff = r_credit;
      if (w_reload)
         for (int i = 0; i < NUM_REQS; i++)
            w_cred_eff[i] = weight_of(r_weights[2*i +: 2]);
      w_elig = '0;
      for (int i = 0; i < NUM_REQS; i++)
         w_elig[i] = bus.reqs[i] && (w_cred_eff[i] != '0);
   end

   arb_4in_rr_pick u_pick (
      .eligible (w_elig),
      .ptr      (r_ptr),
      .pick     (w_pick)
   );

   // Release/expire decode for the current holder and the issue decision.
   always_comb begin
      w_pick_idx = oh2idx(w_pick);
      w_hold_idx = oh2idx(r_grants);
      w_release  = (r_state == GRANT) &&
                   (|(bus.dones & r_grants) || !(|(bus.reqs & r_grants)));
      w_expire   = (r_state == GRANT) && !w_release &&
                   (r_hold == HOLD_BITS'(MAX_HOLD));
      w_issue    = ((r_state == IDLE) || w_release) && (|w_pick);
   end

   // Next credits: reload/decrement, timeout penalty, then config reload
   // overrides everything (including this cycle's decrement).
   always_comb begin
      w_cred_nxt = w_cred_eff;
      if (w_issue)
         w_cred_nxt[w_pick_idx] = w_cred_eff[w_pick_idx] - CRED_BITS'(1);
      if (w_expire)
         w_cred_nxt[w_hold_idx] = '0;
      if (bus.cfg_en)
         for (int i = 0; i < NUM_REQS; i++)
            w_cred_nxt[i] = weight_of(bus.cfg_weights[2*i +: 2]);
   end

   // Grant FSM with registered grants/timeout, pointer, hold counter,
   // credits and weight register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_grants  <= '0;
         r_timeout <= 1'b0;
         r_weights <= '0;
         for (int i = 0; i < NUM_REQS; i++) r_credit[i] <= CRED_BITS'(1);
         r_ptr     <= '0;
         r_hold    <= '0;
      end else begin
         r_credit  <= w_cred_nxt;
         r_timeout <= 1'b0;
         if (bus.cfg_en) r_weights <= bus.cfg_weights;
         if (r_hold != HOLD_BITS'(MAX_HOLD)) r_hold <= r_hold + HOLD_BITS'(1);
         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_grants <= w_pick;
                  r_ptr    <= w_pick_idx + PTR_BITS'(1);
                  r_hold   <= HOLD_BITS'(1);
                  r_state  <= GRANT;
               end
            end
            GRANT: begin
               if (w_expire) begin
                  r_grants  <= '0;
                  r_timeout <= 1'b1;
                  r_state   <= IDLE;
               end else if (w_release) begin
                  if (w_issue) begin
                     r_grants <= w_pick;
                     r_ptr    <= w_pick_idx + PTR_BITS'(1);
                     r_hold   <= HOLD_BITS'(1);
                  end else begin
                     r_grants <= '0;
                     r_state  <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_arb_4in_weighted_lock.sv
// Directed bench for the weighted round-robin arbiter.
module tb_seq_arb_4in_weighted_lock;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   seq_arb_4in_weighted_lock_if bus();

   seq_arb_4in_weighted_lock #(.MAX_HOLD(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   logic [3:0] exp1 [5];
   logic [3:0] exp2 [7];
   logic [3:0] e;
   int         cnt [4];

   initial begin
      n_chk  = 0;
      n_fail = 0;
      exp1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp2 = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0010};
      reset = 1'b0;
      bus.cfg_en = 1'b0;
      bus.cfg_weights = 8'h00;
      bus.reqs = 4'b0000;
      bus.dones = 4'b0000;
      cyc();
      cyc();
      chk("rst_grants", 32'(bus.grants), 32'h0);
      chk("rst_timeout", 32'(bus.timeout), 32'h0);
      reset = 1'b1;

      // default weights, full request, done every cycle
      bus.reqs = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("rr_default", 32'(bus.grants), 32'(exp1[k]));
         bus.dones = bus.grants;
      end
      bus.reqs = 4'b0000;
      bus.dones = 4'b0000;
      do_reset();

      // weight 2 on requester 0, weight 1 on requester 1
      bus.cfg_en = 1'b1;
      bus.cfg_weights = 8'h01;
      cyc();
      bus.cfg_en = 1'b0;
      bus.reqs = 4'b0011;
      for (int k = 0; k < 7; k++) begin
         cyc();
         chk("wrr_2_1", 32'(bus.grants), 32'(exp2[k]));
         bus.dones = bus.grants;
      end
      bus.reqs = 4'b0000;
      bus.dones = 4'b0000;
      do_reset();

      // hold timeout: 15 cycles of grant, one dead cycle with pulse, regrant
      bus.reqs = 4'b0001;
      cyc();
      chk("to_first", 32'(bus.grants), 32'h1);
      for (int k = 0; k < 14; k++) begin
         cyc();
         if (k == 13) chk("to_hold15", 32'(bus.grants), 32'h1);
         if (k == 6)  chk("to_nopulse", 32'(bus.timeout), 32'h0);
      end
      cyc();
      chk("to_gap_grants", 32'(bus.grants), 32'h0);
      chk("to_pulse", 32'(bus.timeout), 32'h1);
      cyc();
      chk("to_regrant", 32'(bus.grants), 32'h1);
      chk("to_pulse_end", 32'(bus.timeout), 32'h0);

      // done arriving on the hold limit cycle wins over the timeout
      repeat (14) cyc();
      bus.dones = 4'b0001;
      cyc();
      chk("done_vs_to_grants", 32'(bus.grants), 32'h1);
      chk("done_vs_to_pulse", 32'(bus.timeout), 32'h0);
      bus.dones = 4'b0000;
      bus.reqs = 4'b0000;
      do_reset();

      // hold 3 cycles, hand over, requester 2 drops after 1 cycle
      bus.reqs = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("hold3", 32'(bus.grants), 32'h1);
      end
      bus.dones = 4'b1010;   // non-holder done bits must be ignored
      cyc();
      chk("ignore_dones", 32'(bus.grants), 32'h1);
      bus.dones = 4'b0001;
      cyc();
      chk("handover_2", 32'(bus.grants), 32'h4);
      bus.dones = 4'b0000;
      bus.reqs = 4'b0001;
      cyc();
      chk("drop_back_0", 32'(bus.grants), 32'h1);

      // asynchronous reset mid-grant
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_grants", 32'(bus.grants), 32'h0);
      chk("async_rst_timeout", 32'(bus.timeout), 32'h0);
      bus.reqs = 4'b1111;
      cyc();
      reset = 1'b1;
      cyc();
      chk("post_rst_first", 32'(bus.grants), 32'h1);

      // reprogram weights while requester 0 holds its grant
      bus.cfg_en = 1'b1;
      bus.cfg_weights = 8'hFF;
      cyc();
      bus.cfg_en = 1'b0;
      chk("cfg_grant_kept", 32'(bus.grants), 32'h1);
      bus.dones = bus.grants;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int k = 0; k < 17; k++) begin
         cyc();
         e = 4'(1 << ((k + 1) % 4));
         if (k == 0 || k == 3 || k == 15 || k == 16)
            chk("w4_seq", 32'(bus.grants), 32'(e));
         if (k < 16)
            for (int i = 0; i < 4; i++) if (bus.grants[i]) cnt[i]++;
         bus.dones = bus.grants;
      end
      for (int i = 0; i < 4; i++) chk("w4_count", 32'(cnt[i]), 32'd4);

      bus.reqs = 4'b0000;
      bus.dones = 4'b0000;
      cyc();
      cyc();
      chk("idle_grants", 32'(bus.grants), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_arb_4in_weighted_lock.md
# seq_arb_4in_weighted_lock

Four-requester weighted round-robin scheduler for a shared multi-cycle resource, such as a memory port or an execution unit. Each grant is one-hot and held until the owning requester signals completion, withdraws its request, or exceeds a hold timeout. Per-requester weights are programmable at run time. The block sits between the requesters and the resource mux and drives the mux select directly from `grants`.

## Interface
- `MAX_HOLD`, default 15: maximum number of consecutive cycles a single grant may stay asserted; legal range 2..255.
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-low reset.
- `cfg_en` input 1: load `cfg_weights` at the next rising edge.
- `cfg_weights` input 8: 2 bits per requester; `[2i+1:2i]` is requester i; effective weight = value + 1 (range 1..4).
- `reqs` input 4: level request per requester.
- `dones` input 4: completion per requester; only the bit of the current grant holder is sampled.
- `grants` output 4: registered one-hot grant, or all zero.
- `timeout` output 1: registered one-cycle pulse on a forced release.

## Operation
- Reset state: `grants`=0000, `timeout`=0, weight register=8'h00 (all weights 1), all credits=1, priority pointer=0, state IDLE.
- Each requester has a 3-bit credit counter. A requester is eligible when its `reqs` bit is 1 and its credit is greater than 0.
- Reload rule: if at least one requester is active but none is eligible, every credit is reloaded from the weights. Selection then uses the reloaded credits in the same cycle.
- Selection is round-robin over eligible requesters, starting at the pointer. After requester i is granted, the pointer becomes (i+1) mod 4.
- On issue, the chosen requester's credit is decremented by 1, and the hold counter is loaded with 1.
- FSM states: IDLE and GRANT.
  - IDLE: if any request is present, issue a grant and go to GRANT; otherwise stay in IDLE.
  - GRANT, holder g: the grant is released when `dones[g]`=1 or `reqs[g]`=0.
    - On release, re-arbitrate at the same edge, so a back-to-back grant is allowed (g may win again if still eligible).
    - If no requester is eligible after release, go to IDLE.
  - GRANT with hold count = `MAX_HOLD` and no done/drop: forced release.
    - `grants`←0000 for exactly one cycle and `timeout`←1 for one cycle.
    - credit[g]←0.
    - Next state IDLE.
- Done and timeout in the same cycle: done wins and no `timeout` pulse is issued.
- `cfg_en`: the weight register is updated and all credits are reloaded from the new weights at the same edge. Any current grant and the pointer are unaffected.
- `cfg_en` coinciding with an issue: the issue uses the old credits, and the reload then overwrites them, including the decrement.
- `dones` bits for non-holders are ignored. A new request appearing during GRANT waits for release.

## Timing
- Latency from request to grant is 1 cycle: `reqs` sampled at edge k produce `grants` valid after edge k.
- Minimum hold is 1 cycle.
- Release to next grant takes 0 dead cycles for done/drop releases and 1 dead cycle after a timeout.
- The hold counter is `$clog2(MAX_HOLD+1)` bits wide and saturates; the credit counter never underflows.
- Asserting `reset` mid-grant clears `grants` and `timeout` immediately, without waiting for a clock edge, and restores all reset values. Deassertion is synchronized externally.

## Structure
- A shared package holds the `NUM_REQS`=4 constant, the weight and credit widths, and the `state_t` enum {IDLE, GRANT}.
- One combinational sub-module, `arb_4in_rr_pick` (inputs: eligible[3:0] and ptr[1:0]; output: one-hot pick), is instantiated once.
- The top level contains the FSM, credits, pointer, hold counter, and weight register.

## Test plan
- Default weights, `reqs`=1111, `dones`=`grants` → `grants` follow 0001, 0010, 0100, 1000, 0001 with no gaps.
- `cfg_weights`=8'h01, `reqs`=0011, `dones`=`grants` → `grants` follow 0001, 0010, 0001, 0010, 0001, 0001, 0010, so requester 0 receives 2 of every 3 grants in steady state.
- `reqs`=0001 with `dones`=0 → `grants`=0001 for 15 cycles, then 0000 for one cycle with `timeout`=1, then 0001 again.
- `reqs`=0101 with requester 0 held 3 cycles and requester 2 then dropping its request after 1 cycle → `grants` follow 0001 ×3, 0100 ×1, 0001.
- `reset` asserted low mid-grant → `grants`=0000 before the next edge; after release, `reqs`=1111 yields 0001 first.
- `cfg_en` pulsed during a grant with 8'hFF → the current grant is unchanged; afterwards each requester is granted 4 times per round.
